// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache miss fill engine: block geometry, the fill
// FSM state type, cache-select encodings and a block-base helper.
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;

    localparam logic SEL_ICACHE = 1'b0;
    localparam logic SEL_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // Clears the byte offset so the address points at the start of its block.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/fill_counter.sv
// -----------------------------------------------------------------------------
// fill_counter
// 4-bit up-counter with enable, synchronous clear and a terminal-count flag.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   en       in   increment when high
//   clr      in   synchronous clear (wins over en)
//   count    out  current count
//   tc       out  high while count == TC_VALUE
// -----------------------------------------------------------------------------
module fill_counter #(
    parameter logic [3:0] TC_VALUE = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] count,
    output logic       tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/cache_miss_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_miss_fill_fsm
// Memory-side responder for I-cache and D-cache misses. Arbitrates concurrent
// misses (D first), streams one 8-word block from pipelined main memory into
// the selected cache data array, then writes the tag for one cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_miss/_addr      I-cache miss request and byte address
//   d_miss/_addr      D-cache miss request and byte address
//   mem_en/mem_addr   one word read request per cycle
//   mem_data_valid    returned word strobe, mem_data returned word
//   fill_we           data array write, fill_word index, fill_data word
//   fill_sel          target cache (0 = I, 1 = D), fill_addr block base
//   tag_we            one-cycle tag/valid write for fill_addr
//   i_stall, d_stall  stage stalls
//
// State | meaning
// IDLE  | waiting for a miss; latches base and sel on acceptance
// FILL  | issuing 8 reads and writing returned words
// DONE  | tag/valid write, counters cleared
// -----------------------------------------------------------------------------
import cache_pkg::*;

module cache_miss_fill_fsm (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [2:0]        fill_word,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              tag_we,
    output logic              i_stall,
    output logic              d_stall
);

    fill_state_t       state, state_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic              sel_q, sel_nxt;

    logic [3:0] issue_cnt, recv_cnt;
    logic       issue_done, recv_last;
    logic       issue_en, recv_en, cnt_clr;
    logic       busy;

    fill_counter #(.TC_VALUE(4'(WORDS_PER_BLOCK))) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_en),
        .clr   (cnt_clr),
        .count (issue_cnt),
        .tc    (issue_done)
    );

    fill_counter #(.TC_VALUE(4'(WORDS_PER_BLOCK - 1))) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (recv_en),
        .clr   (cnt_clr),
        .count (recv_cnt),
        .tc    (recv_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            base_q <= '0;
            sel_q  <= SEL_ICACHE;
        end else begin
            state  <= state_nxt;
            base_q <= base_nxt;
            sel_q  <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        sel_nxt   = sel_q;
        issue_en  = 1'b0;
        recv_en   = 1'b0;
        cnt_clr   = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_we   = 1'b0;
        fill_word = 3'd0;
        tag_we    = 1'b0;

        unique case (state)
            IDLE: begin
                // D wins a tie: it belongs to the older instruction.
                if (d_miss) begin
                    state_nxt = FILL;
                    sel_nxt   = SEL_DCACHE;
                    base_nxt  = block_base(d_miss_addr);
                end else if (i_miss) begin
                    state_nxt = FILL;
                    sel_nxt   = SEL_ICACHE;
                    base_nxt  = block_base(i_miss_addr);
                end
            end
            FILL: begin
                if (!issue_done) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + {{(ADDR_W-5){1'b0}}, issue_cnt, 1'b0};
                    issue_en = 1'b1;
                end
                // recv_cnt[3] guards against writes past the last word.
                if (mem_data_valid && !recv_cnt[3]) begin
                    fill_we   = 1'b1;
                    fill_word = recv_cnt[2:0];
                    recv_en   = 1'b1;
                    if (recv_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                tag_we    = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign fill_sel  = sel_q;
    assign fill_addr = base_q;
    assign fill_data = mem_data;
    assign i_stall   = i_miss | (busy & (sel_q == SEL_ICACHE));
    assign d_stall   = d_miss | (busy & (sel_q == SEL_DCACHE));

endmodule
